// File: rtl/irrigation_zone_scheduler_if.sv
// irrigation_zone_scheduler_if: sensor/enable inputs and pump/valve/status outputs of the zone scheduler
interface irrigation_zone_scheduler_if #(
  parameter int NUM_ZONES = 4
);
  localparam int ZW = $clog2(NUM_ZONES);
  logic [4*NUM_ZONES-1:0] sensor;
  logic [NUM_ZONES-1:0]   enable;
  logic [NUM_ZONES-1:0]   valve;
  logic                   pump;
  logic                   busy;
  logic [ZW-1:0]          active_zone;
  logic [NUM_ZONES-1:0]   timeout;
  modport master (output sensor, enable, input valve, pump, busy, active_zone, timeout);
  modport slave  (input sensor, enable, output valve, pump, busy, active_zone, timeout);
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler: round-robin sharing of one pump among dry zones with settle/rest sequencing
module irrigation_zone_scheduler #(
  parameter int         NUM_ZONES = 4,
  parameter logic [3:0] THRESHOLD = 4'd4,
  parameter logic [3:0] HYST      = 4'd2,
  parameter int         SETTLE    = 3,
  parameter int         MAX_ON    = 20,
  parameter int         REST      = 20
) (
  input logic                     clk,
  input logic                     reset,
  irrigation_zone_scheduler_if.slave bus
);
  localparam int         ZW        = $clog2(NUM_ZONES);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0] MAX_M1    = 8'(MAX_ON - 1);
  localparam logic [7:0] REST_M1   = 8'(REST - 1);
  localparam logic [4:0] STOP_LVL  = 5'(THRESHOLD) + 5'(HYST);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_PUMP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_REST   = 3'd4
  } state_t;
  state_t               r_state, w_state;
  logic [7:0]           r_cnt, w_cnt;
  logic [NUM_ZONES-1:0] r_valve, w_valve, r_timeout, w_timeout, w_req;
  logic                 r_pump, w_pump, r_busy, w_busy;
  logic [ZW-1:0]        r_zone, w_zone, r_ptr, w_ptr, w_gnt;
  logic                 w_any, w_en_g;
  logic [3:0]           w_sens_g;
  genvar i;
  for (i = 0; i < NUM_ZONES; i++) begin : g_req
    assign w_req[i] = bus.enable[i] && (bus.sensor[4*i +: 4] < THRESHOLD);
  end
  assign w_sens_g = bus.sensor[4*r_zone +: 4];
  assign w_en_g   = bus.enable[r_zone];
  // round-robin pick: scanning from farthest to nearest leaves the first requester after the pointer
  always_comb begin
    w_any = 1'b0;
    w_gnt = r_ptr;
    for (int k = NUM_ZONES; k >= 1; k--) begin
      if (w_req[(int'(r_ptr) + k) % NUM_ZONES]) begin
        w_any = 1'b1;
        w_gnt = ZW'((int'(r_ptr) + k) % NUM_ZONES);
      end
    end
  end
  // watering sequence: next state and next registered outputs
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_valve   = r_valve;
    w_pump    = r_pump;
    w_busy    = r_busy;
    w_zone    = r_zone;
    w_ptr     = r_ptr;
    w_timeout = r_timeout;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_state = S_SETTLE;
        w_valve = NUM_ZONES'(1) << w_gnt;
        w_zone  = w_gnt;
        w_ptr   = w_gnt;
        w_busy  = 1'b1;
        w_cnt   = SETTLE_M1;
      end
      S_SETTLE: if (!w_en_g) begin
        w_state = S_REST;
        w_valve = '0;
        w_cnt   = REST_M1;
      end else if (r_cnt == 8'd0) begin
        w_state = S_PUMP;
        w_pump  = 1'b1;
        w_cnt   = MAX_M1;
      end else begin
        w_cnt = r_cnt - 8'd1;
      end
      S_PUMP: if (!w_en_g || {1'b0, w_sens_g} >= STOP_LVL || r_cnt == 8'd0) begin
        w_state = S_DRAIN;
        w_pump  = 1'b0;
        w_cnt   = SETTLE_M1;
        if (w_en_g && {1'b0, w_sens_g} < STOP_LVL) w_timeout[r_zone] = 1'b1;
      end else begin
        w_cnt = r_cnt - 8'd1;
      end
      S_DRAIN: if (r_cnt == 8'd0) begin
        w_state = S_REST;
        w_valve = '0;
        w_cnt   = REST_M1;
      end else begin
        w_cnt = r_cnt - 8'd1;
      end
      S_REST: if (r_cnt == 8'd0) begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end else begin
        w_cnt = r_cnt - 8'd1;
      end
      default: begin
        w_state   = S_IDLE;
        w_cnt     = '0;
        w_valve   = '0;
        w_pump    = 1'b0;
        w_busy    = 1'b0;
        w_zone    = '0;
        w_timeout = '0;
      end
    endcase
  end
  // state register; async reset drops pump and valves without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_valve   <= '0;
      r_pump    <= 1'b0;
      r_busy    <= 1'b0;
      r_zone    <= '0;
      r_ptr     <= ZW'(NUM_ZONES - 1);
      r_timeout <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_valve   <= w_valve;
      r_pump    <= w_pump;
      r_busy    <= w_busy;
      r_zone    <= w_zone;
      r_ptr     <= w_ptr;
      r_timeout <= w_timeout;
    end
  end
  assign bus.valve       = r_valve;
  assign bus.pump        = r_pump;
  assign bus.busy        = r_busy;
  assign bus.active_zone = r_zone;
  assign bus.timeout     = r_timeout;
endmodule

// File: doc/irrigation_zone_scheduler.md
Name: irrigation_zone_scheduler

Overview:
- Shares one water pump between NUM_ZONES irrigation zones. Each zone has its own 4-bit soil moisture sensor and its own valve.
- Grants the pump to one dry zone at a time, using round-robin order among the requesting zones.
- Sequences each watering cycle in this order: valve open, pump on, pump off, valve close, rest.
- Sits between the per-zone sensor inputs and the pump/valve drivers. Replaces any single-zone pump control.

Parameters:
- NUM_ZONES, 4, number of zones (2..16). Derived ZW = $clog2(NUM_ZONES).
- THRESHOLD, 4'd4, a zone is dry when its sensor < THRESHOLD.
- HYST, 4'd2, the pump stops when sensor >= THRESHOLD+HYST. The sum must be <= 15.
- SETTLE, 3, cycles the valve is open before pump on, and again after pump off (1..255).
- MAX_ON, 20, maximum pump-on cycles per grant (1..255).
- REST, 20, idle cycles after each grant before the next arbitration (1..255).

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- sensor, input, 4*NUM_ZONES, moisture readings; zone i occupies bits [4i+3:4i].
- enable, input, NUM_ZONES, per-zone enable; a disabled zone never requests.
- valve, output, NUM_ZONES, registered, one-hot or all zero, valve drive.
- pump, output, 1, registered pump drive.
- busy, output, 1, registered; high in every state except IDLE.
- active_zone, output, ZW, registered index of the granted zone; holds its last value when IDLE.
- timeout, output, NUM_ZONES, registered, sticky: zone i hit MAX_ON at least once.

Behaviour:
- Reset (async, high): state=IDLE; valve=0, pump=0, busy=0, active_zone=0, timeout=0, counter=0. The round-robin pointer is set so that zone 0 has the highest priority first.
- Reset mid-operation turns the pump and valves off at once, without waiting for a clock edge.
- Zone i requests when enable[i] && sensor_i < THRESHOLD. Requests are sampled only in IDLE.
- Counter is 8 bits and loaded with P-1, so each timed state lasts exactly P cycles.
- IDLE, no request: stay in IDLE; all outputs hold.
- IDLE, any request:
  - Grant g = first requesting zone strictly after the last grant, wrapping modulo NUM_ZONES.
  - Next edge: state=SETTLE, valve=onehot(g), active_zone=g, busy=1, counter=SETTLE-1. Pointer := g.
- SETTLE (valve open, pump=0):
  - If enable[g] falls: go to REST; valve=0 next edge; counter=REST-1.
  - Else when counter==0: go to PUMPING; pump=1; counter=MAX_ON-1.
  - Otherwise decrement the counter.
- PUMPING (pump=1, valve open), stop conditions in priority order:
  - (a) !enable[g] or sensor_g >= THRESHOLD+HYST: go to DRAIN.
  - (b) counter==0: go to DRAIN and set timeout[g]=1.
  - (c) otherwise decrement the counter.
  - On entering DRAIN: pump=0 next edge; counter=SETTLE-1.
  - The pump is therefore high for at most MAX_ON consecutive cycles. If (a) and (b) occur in the same cycle, (a) wins and timeout is not set.
- DRAIN (pump=0, valve open): when counter==0, go to REST; valve=0; counter=REST-1.
- REST (all outputs off, busy=1): when counter==0, go to IDLE; busy=0.
- Pump/valve invariants:
  - pump=1 only while exactly one valve bit is set.
  - The valve always opens at least SETTLE cycles before the pump starts, and closes SETTLE cycles after it stops.
  - At most one valve bit is ever high.
- Sensor and enable changes on non-granted zones have no effect until the next IDLE.
- The sensor value of zone g is ignored outside PUMPING.
- An illegal state encoding recovers to IDLE with all outputs zero.

Test Plan:
- Reset check: assert reset mid-PUMPING. valve=0 and pump=0 immediately, without a clock edge. After release: IDLE, busy=0, timeout=0.
- Single zone, all defaults: sensor0=2, the rest=9, enable=4'hF.
  - valve=4'b0001 one cycle after request; pump rises 3 cycles later.
  - Set sensor0=6 after 5 pump cycles: pump falls next edge, valve falls 3 cycles later.
  - busy drops after 20 REST cycles.
- Timeout: sensor1=0 held, enable=4'b0010. Pump is high for exactly 20 cycles, timeout=4'b0010, then DRAIN/REST, then re-grant of zone 1.
- Round-robin: all four sensors=1 and held. Grant order is 0,1,2,3,0. active_zone matches each grant. valve is never multi-hot.
- Enable drop in SETTLE: clear enable[g] during SETTLE. pump never rises; valve clears next edge; state goes to REST.
- Hysteresis/tie: sensor_g=5 during PUMPING keeps pumping. sensor_g=6 on the cycle counter==0 causes a stop with no timeout bit set.
